// File: rtl/argmax_pipe.sv
// Pipelined argmax: binary reduction tree of LAT registered stages with a global stall.
// Define ARGMAX_SIGNED_EN to compare scores as two's-complement instead of unsigned.
module argmax_pipe #(
    parameter  int N_CLASSES = 10,
    parameter  int SCORE_W   = 26,
    localparam int IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1,
    localparam int LAT       = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_CLASSES*SCORE_W-1:0]   in_scores,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_W-1:0]               out_index,
    output logic [SCORE_W-1:0]             out_score
);

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [IDX_W-1:0]   idx_t;

    // Survivors left after stage s; s = -1 means the raw input vector.
    function automatic int level_count(input int s);
        int c;
        c = N_CLASSES;
        for (int k = 0; k <= s; k++) c = (c + 1) / 2;
        return c;
    endfunction

    // Lower-index candidate a keeps the slot on ties.
    function automatic logic a_wins(input score_t a, input score_t b);
`ifdef ARGMAX_SIGNED_EN
        return $signed(a) >= $signed(b);
`else
        return a >= b;
`endif
    endfunction

    logic             en;
    logic [LAT-1:0]   stage_valid;
    score_t           stage_score [LAT][N_CLASSES];
    idx_t             stage_idx   [LAT][N_CLASSES];
    score_t           nxt_score   [LAT][N_CLASSES];
    idx_t             nxt_idx     [LAT][N_CLASSES];
    score_t           src_score   [2*N_CLASSES];
    idx_t             src_idx     [2*N_CLASSES];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        for (int s = 0; s < LAT; s++) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                nxt_score[s][i] = '0;
                nxt_idx[s][i]   = '0;
            end
        end
        for (int k = 0; k < 2*N_CLASSES; k++) begin
            src_score[k] = '0;
            src_idx[k]   = '0;
        end

        for (int s = 0; s < LAT; s++) begin
            for (int k = 0; k < 2*N_CLASSES; k++) begin
                src_score[k] = '0;
                src_idx[k]   = '0;
            end
            // Bubbles enter as zero data so invalid slots never show stale scores.
            for (int k = 0; k < N_CLASSES; k++) begin
                if (s == 0) begin
                    src_score[k] = in_valid ? in_scores[k*SCORE_W +: SCORE_W] : '0;
                    src_idx[k]   = idx_t'(k);
                end else if (k < level_count(s - 1)) begin
                    src_score[k] = stage_score[(s == 0) ? 0 : s - 1][k];
                    src_idx[k]   = stage_idx[(s == 0) ? 0 : s - 1][k];
                end
            end
            for (int i = 0; i < N_CLASSES; i++) begin
                if (i < level_count(s)) begin
                    if (2*i + 1 < level_count(s - 1)) begin
                        if (a_wins(src_score[2*i], src_score[2*i+1])) begin
                            nxt_score[s][i] = src_score[2*i];
                            nxt_idx[s][i]   = src_idx[2*i];
                        end else begin
                            nxt_score[s][i] = src_score[2*i+1];
                            nxt_idx[s][i]   = src_idx[2*i+1];
                        end
                    end else begin
                        nxt_score[s][i] = src_score[2*i];
                        nxt_idx[s][i]   = src_idx[2*i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            for (int s = 0; s < LAT; s++) begin
                for (int i = 0; i < N_CLASSES; i++) begin
                    stage_score[s][i] <= '0;
                    stage_idx[s][i]   <= '0;
                end
            end
        end else if (en) begin
            stage_valid[0] <= in_valid;
            for (int s = 1; s < LAT; s++) stage_valid[s] <= stage_valid[s-1];
            for (int s = 0; s < LAT; s++) begin
                for (int i = 0; i < N_CLASSES; i++) begin
                    stage_score[s][i] <= nxt_score[s][i];
                    stage_idx[s][i]   <= nxt_idx[s][i];
                end
            end
        end
    end

    assign out_valid = stage_valid[LAT-1];
    assign out_index = stage_idx[LAT-1][0];
    assign out_score = stage_score[LAT-1][0];

endmodule

// File: tb/tb_argmax_pipe.sv
// Self-checking bench for argmax_pipe: directed table, streaming, backpressure, reset and random traffic.
module tb_argmax_pipe;

    localparam int N     = 10;
    localparam int W     = 26;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int LAT   = (N > 1) ? $clog2(N) : 1;

    typedef logic [N*W-1:0] vec_bits_t;
    typedef struct {
        string        name;
        vec_bits_t    scores;
        int           exp_idx;
        logic [W-1:0] exp_score;
    } vec_t;
    typedef struct {
        int           idx;
        logic [W-1:0] score;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    vec_bits_t        in_scores;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [W-1:0]     out_score;

    int        tests_run    = 0;
    int        tests_failed = 0;
    int        out_count    = 0;
    exp_t      exp_q[$];
    vec_t      tbl[4];
    logic      hold_prev = 1'b0;
    logic [IDX_W-1:0] hold_idx;
    logic [W-1:0]     hold_score;

    argmax_pipe #(.N_CLASSES(N), .SCORE_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_scores (in_scores),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_score (out_score)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strictly-greater test for the linear scan; first maximum found keeps the win.
    function automatic bit beats(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    function automatic exp_t model(input vec_bits_t v);
        exp_t e;
        e.idx   = 0;
        e.score = v[0 +: W];
        for (int k = 1; k < N; k++) begin
            if (beats(v[k*W +: W], e.score)) begin
                e.idx   = k;
                e.score = v[k*W +: W];
            end
        end
        return e;
    endfunction

    function automatic vec_bits_t rand_vec();
        vec_bits_t v;
        int mode;
        mode = $urandom_range(0, 2);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       v[k*W +: W] = W'($urandom);
                1:       v[k*W +: W] = W'($urandom_range(0, 3));
                default: case ($urandom_range(0, 3))
                             0:       v[k*W +: W] = '0;
                             1:       v[k*W +: W] = W'(1);
                             2:       v[k*W +: W] = '1;
                             default: v[k*W +: W] = W'(26'h2000000);
                         endcase
            endcase
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the vector until it is accepted; waits reports stalled cycles.
    task automatic applyStimulus(input vec_bits_t v, output int waits);
        bit acc;
        acc       = 1'b0;
        waits     = 0;
        in_valid  = 1'b1;
        in_scores = v;
        while (!acc && waits <= 100) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (!acc) waits++;
        end
        in_valid = 1'b0;
        if (!acc) checkOutput("accept_timeout", acc, 1);
    endtask

    task automatic apply_table(input vec_t e);
        in_valid  = 1'b1;
        in_scores = e.scores;
        @(negedge clk);
        checkOutput({e.name, "_in_ready"}, in_ready, 1);
        tick();
        in_valid  = 1'b0;
        in_scores = rand_vec();
        for (int j = 0; j <= LAT; j++) begin
            @(negedge clk);
            checkOutput({e.name, "_valid"}, out_valid, (j == LAT-1));
            if (j == LAT-1) begin
                checkOutput({e.name, "_index"}, out_index, e.exp_idx);
                checkOutput({e.name, "_score"}, out_score, e.exp_score);
            end
            tick();
        end
    endtask

    task automatic drain(input int expect_outs, input int start_count);
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        checkOutput("drain_queue_empty", exp_q.size(), 0);
        if (expect_outs >= 0) checkOutput("drain_out_count", out_count - start_count, expect_outs);
    endtask

    // Scoreboard: every accepted vector must leave once, in order, and hold while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_index", out_index, hold_idx);
                checkOutput("hold_score", out_score, hold_score);
            end
            hold_prev  = out_valid && !out_ready;
            hold_idx   = out_index;
            hold_score = out_score;
            if (in_valid && in_ready) exp_q.push_back(model(in_scores));
            if (out_valid && out_ready) begin
                out_count++;
                checkOutput("sb_queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("sb_index", out_index, e.idx);
                    checkOutput("sb_score", out_score, e.score);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_bits_t stream_v[8];
        int        waits;
        int        start;
        bit        seen;

        tbl[0].name = "basic_max";
        for (int k = 0; k < N; k++) tbl[0].scores[k*W +: W] = W'(100 * (k + 1));
        tbl[0].exp_idx = 9;  tbl[0].exp_score = W'(1000);
        tbl[1].name = "tie_3_7";
        for (int k = 0; k < N; k++) tbl[1].scores[k*W +: W] = (k == 3 || k == 7) ? W'(5000) : W'(10);
        tbl[1].exp_idx = 3;  tbl[1].exp_score = W'(5000);
        tbl[2].name = "all_equal";
        for (int k = 0; k < N; k++) tbl[2].scores[k*W +: W] = W'(42);
        tbl[2].exp_idx = 0;  tbl[2].exp_score = W'(42);
        tbl[3].name = "sign_case";
        for (int k = 0; k < N; k++) tbl[3].scores[k*W +: W] = W'(26'h2000000);
        tbl[3].scores[2*W +: W] = W'(26'h3FFFFFF);
        tbl[3].scores[5*W +: W] = W'(26'h0000001);
`ifdef ARGMAX_SIGNED_EN
        tbl[3].exp_idx = 5;  tbl[3].exp_score = W'(26'h0000001);
`else
        tbl[3].exp_idx = 2;  tbl[3].exp_score = W'(26'h3FFFFFF);
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_scores = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_index", out_index, 0);
        checkOutput("reset_out_score", out_score, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        tick();

        for (int t = 0; t < 4; t++) apply_table(tbl[t]);

        // Streaming: eight back-to-back vectors, winner at class i.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) stream_v[i][k*W +: W] = W'($urandom_range(0, 999));
            stream_v[i][(i % N)*W +: W] = W'(5000);
        end
        start = out_count;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus(stream_v[i], waits);
                    checkOutput("stream_in_ready_waits", waits, 0);
                end
            end
            begin
                int n;
                seen = 1'b0;
                n    = 0;
                while (!seen && n < 20) begin
                    @(negedge clk);
                    seen = out_valid;
                    n++;
                end
                checkOutput("stream_first_valid", seen, 1);
                for (int i = 0; i < 8; i++) begin
                    checkOutput("stream_valid", out_valid, 1);
                    checkOutput("stream_index", out_index, i);
                    if (i < 7) @(negedge clk);
                end
            end
        join
        drain(8, start);

        // Backpressure: stall the output for three cycles mid-stream.
        start = out_count;
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(rand_vec(), waits);
            end
            begin
                int n;
                seen = 1'b0;
                n    = 0;
                while (!seen && n < 20) begin
                    @(negedge clk);
                    seen = out_valid;
                    n++;
                end
                checkOutput("bp_first_valid", seen, 1);
                tick();
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready_low", in_ready, 0);
                    checkOutput("bp_out_valid_high", out_valid, 1);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain(6, start);

        // Reset with three vectors in flight; input offered during reset must be dropped.
        for (int i = 0; i < 3; i++) applyStimulus(rand_vec(), waits);
        tick();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_scores = rand_vec();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < LAT; j++) begin
            @(negedge clk);
            checkOutput("rst_flush_valid", out_valid, 0);
            checkOutput("rst_flush_index", out_index, 0);
            checkOutput("rst_flush_score", out_score, 0);
            tick();
        end
        apply_table(tbl[0]);

        // Random traffic with random backpressure against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_scores = rand_vec();
            tick();
        end
        drain(-1, out_count);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/argmax_pipe.md
Name: argmax_pipe

Overview:
- Parametrised, fully pipelined argmax over N_CLASSES unsigned scores from the classifier's final accumulators.
- Returns the winning class index and its score.
- Adds valid/ready handshaking, a global stall, and a deterministic tie-break.
- Sits between the per-class score accumulators and the result/output interface.

Parameters:
- N_CLASSES, 10, number of scores compared; legal range 1..64.
- SCORE_W, 26, width of each score in bits.
- IDX_W, clog2(N_CLASSES) with a minimum of 1, width of the index output (derived localparam, not overridable).
- LAT, clog2(N_CLASSES) with a minimum of 1, pipeline latency in cycles (derived localparam).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  score vector valid
- in_ready  out  1  block can accept a vector this cycle
- in_scores  in  N_CLASSES*SCORE_W  packed scores; class k occupies bits [k*SCORE_W +: SCORE_W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_index  out  IDX_W  index of the maximum score
- out_score  out  SCORE_W  value of the maximum score

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - All stage valid bits, out_valid, out_index and out_score clear to 0.
  - All stage data registers clear to 0.
  - rst mid-operation discards every in-flight vector; no result from before reset ever appears afterwards.
- Structure: binary reduction tree of LAT registered stages.
  - Stage s pairs adjacent survivors of stage s-1.
  - An odd survivor passes through its stage registered, with score and index unchanged.
  - The final stage drives out_* directly from registers; no combinational path from in_* to out_*.
- Compare rule:
  - Candidate A (lower index) beats B (higher index) if A >= B.
  - Ties therefore resolve to the lowest class index.
  - Compare is unsigned and SCORE_W bits wide; no widening or truncation of scores.
- Handshake and stall:
  - en = !out_valid | out_ready.
  - in_ready = en, combinational from out_valid and out_ready only.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - When en=1, every stage advances one step. Stage 0 valid takes in_valid & in_ready; stage k valid takes stage k-1 valid.
  - When en=0, all stage registers hold their value, including data and valid.
  - in_scores is ignored when in_valid=0 or in_ready=0.
- Latency and throughput:
  - With out_ready held at 1, a vector accepted at edge t appears with out_valid=1 after edge t+LAT-1. LAT=4 for N_CLASSES=10.
  - Throughput is one vector per cycle.
  - Bubbles are not collapsed: an invalid slot occupies a stage like a valid one.
- Holding output: while out_valid=1 and out_ready=0, out_index and out_score are stable.
- N_CLASSES=1: a single register stage; out_index is always 0.
- Simultaneous rst and in_valid: rst wins and the input is not accepted.

Optional Feature:
- Macro ARGMAX_SIGNED_EN.
- Defined: scores are two's-complement. All comparisons are signed, e.g. 26'h3FFFFFF (-1) loses to 26'h0000000. Tie-break is unchanged.
- Undefined: all comparisons are unsigned, and 26'h3FFFFFF is the maximum value.

Test Plan:
- Basic max: N=10, out_ready=1. Scores 100,200,...,1000 with class 9 = 1000; one vector at cycle 0 -> out_valid=1 with out_index=9, out_score=1000 exactly LAT=4 cycles later, and out_valid=0 on the next cycle.
- Tie-break: class 3 = class 7 = 5000, all others 10 -> out_index=3, out_score=5000. All classes 42 -> out_index=0.
- Streaming: 8 back-to-back vectors with the max at class (i mod 10), out_ready=1 -> 8 consecutive out_valid cycles with indices 0..7 in order and in_ready constantly 1.
- Backpressure: stream 6 vectors and drop out_ready for 3 cycles while out_valid=1 ->
  - in_ready=0 and out_* stable during the stall.
  - No loss or duplication; all 6 results arrive in order after release.
- Reset mid-flight: accept 3 vectors, assert rst for 1 cycle one cycle later -> out_valid stays 0 for LAT cycles after reset, out_index=0, out_score=0, and a new vector afterwards yields a correct result.
- Signed mode (ARGMAX_SIGNED_EN defined): class 2 = 26'h3FFFFFF, class 5 = 26'h0000001, others 26'h2000000 -> out_index=5. Without the macro the same vector -> out_index=2.
